// File: rtl/imm_enc_pkg.sv
// Shared types for the RISC-V instruction encoder: formats, opcodes and the
// stage-1 payload carried into the packing stage.
package imm_enc_pkg;

   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic        err;
   } stage_t;

endpackage

// File: rtl/imm_range_chk.sv
// Combinational immediate legality check: range, alignment and format code.
module imm_range_chk
   import imm_enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   output logic        err
);

   // A field "fits" when every bit above the encodable width equals the sign.
   logic fits_12, fits_13, fits_21;
   assign fits_12 = (&imm[31:11]) || (~|imm[31:11]);
   assign fits_13 = (&imm[31:12]) || (~|imm[31:12]);
   assign fits_21 = (&imm[31:20]) || (~|imm[31:20]);

   always_comb begin
      err = 1'b1;
      case (fmt)
         FMT_I, FMT_S: err = !fits_12;
         FMT_B:        err = !fits_13 || imm[0];
         FMT_J:        err = !fits_21 || imm[0];
         FMT_U:        err = |imm[11:0];
         default:      err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction encoder: stage 1 registers and range-checks,
// stage 2 scatters immediate bits into the selected format.
module imm_encoder
   import imm_enc_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [ERR_W-1:0] err_count
);

   function automatic logic [31:0] pack_inst(input stage_t p);
      logic [31:0] w;
      w = 32'd0;
      case (p.fmt)
         FMT_I: w = {p.imm[11:0], p.rs1, p.funct3, p.rd, p.opcode};
         FMT_S: w = {p.imm[11:5], p.rs2, p.rs1, p.funct3, p.imm[4:0], p.opcode};
         FMT_B: w = {p.imm[12], p.imm[10:5], p.rs2, p.rs1, p.funct3,
                     p.imm[4:1], p.imm[11], p.opcode};
         FMT_U: w = {p.imm[31:12], p.rd, p.opcode};
         FMT_J: w = {p.imm[20], p.imm[10:1], p.imm[11], p.imm[19:12], p.rd, p.opcode};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   stage_t            s1_reg;
   stage_t            s1_next;
   logic              s1_valid_reg;
   logic              s1_err;
   logic              out_valid_reg;
   logic [31:0]       out_inst_reg;
   logic              out_err_reg;
   logic [CNT_W-1:0]  enc_count_reg;
   logic [ERR_W-1:0]  err_count_reg;
   logic              s2_ready;
   logic              unused_funct7;

   // funct7 has no slot in any format handled here.
   assign unused_funct7 = ^in_funct7;

   imm_range_chk u_chk (
      .fmt (in_fmt),
      .imm (in_imm),
      .err (s1_err)
   );

   always_comb begin
      s1_next        = '0;
      s1_next.fmt    = in_fmt;
      s1_next.opcode = in_opcode;
      s1_next.rd     = in_rd;
      s1_next.rs1    = in_rs1;
      s1_next.rs2    = in_rs2;
      s1_next.funct3 = in_funct3;
      s1_next.imm    = in_imm;
      s1_next.err    = s1_err;
   end

   // Backpressure is combinational from out_ready; only registered state feeds back.
   assign s2_ready = !out_valid_reg || out_ready;
   assign in_ready = rst_n && (!s1_valid_reg || s2_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_reg        <= '0;
         s1_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_inst_reg  <= 32'd0;
         out_err_reg   <= 1'b0;
         enc_count_reg <= '0;
         err_count_reg <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid)
               s1_reg <= s1_next;
         end
         if (s2_ready) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               out_inst_reg <= pack_inst(s1_reg);
               out_err_reg  <= s1_reg.err;
            end
         end
         if (out_valid_reg && out_ready) begin
            enc_count_reg <= enc_count_reg + 1'b1;
            if (out_err_reg && !(&err_count_reg))
               err_count_reg <= err_count_reg + 1'b1;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_inst  = out_inst_reg;
   assign out_err   = out_err_reg;
   assign enc_count = enc_count_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: per-format vectors, boundaries, stalls, reset.
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [15:0] enc_count;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   imm_encoder #(.CNT_W(16), .ERR_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request and hold it until accepted; returns on the falling edge after acceptance.
   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm);
      int n;
      @(negedge clk);
      in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_imm = imm; in_funct7 = 7'h55; in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // One transaction with out_ready high: returns the word, its flag and the latency in cycles.
   task automatic single(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] imm, output logic [31:0] inst, output logic err,
                         output int lat);
      send(f, op, rd, rs1, rs2, f3, imm);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk); lat++;
      end
      inst = out_inst;
      err  = out_err;
      $display("txn fmt=%0d imm=%08h inst=%08h err=%0b lat=%0d", f, imm, inst, err, lat);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got=%08h exp=00000000", out_inst); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
      checks++; if (enc_count !== 16'd0 || err_count !== 8'd0) begin
         errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", enc_count, err_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_i_s();
      logic [31:0] inst; logic err; int lat;
      single(3'd0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'hFFFFFFFC, inst, err, lat);
      checks++; if (inst !== 32'hFFC12283 || err !== 1'b0) begin errors++; $display("FAIL i_load got=%08h/%0b exp=FFC12283/0", inst, err); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL i_latency got=%0d exp=2", lat); end
      single(3'd1, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'b010, 32'hFFFFFFF8, inst, err, lat);
      checks++; if (inst !== 32'hFE312C23 || err !== 1'b0) begin errors++; $display("FAIL s_store got=%08h/%0b exp=FE312C23/0", inst, err); end
   endtask

   task automatic test_branch();
      logic [31:0] inst; logic err; int lat;
      single(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8, inst, err, lat);
      checks++; if (inst !== 32'h00208463 || err !== 1'b0) begin errors++; $display("FAIL b_plus8 got=%08h/%0b exp=00208463/0", inst, err); end
      single(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'd7, inst, err, lat);
      checks++; if (inst !== 32'h00208363 || err !== 1'b1) begin errors++; $display("FAIL b_odd got=%08h/%0b exp=00208363/1", inst, err); end
      checks++; if (err_count !== 8'd1 || enc_count !== 16'd4) begin
         errors++; $display("FAIL b_counters got=%0d/%0d exp=4/1", enc_count, err_count);
      end
   endtask

   task automatic test_i_bounds();
      logic [31:0] inst; logic err; int lat;
      single(3'd0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'd2047, inst, err, lat);
      checks++; if (inst !== 32'h7FF12283 || err !== 1'b0) begin errors++; $display("FAIL i_2047 got=%08h/%0b exp=7FF12283/0", inst, err); end
      single(3'd0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'd2048, inst, err, lat);
      checks++; if (inst !== 32'h80012283 || err !== 1'b1) begin errors++; $display("FAIL i_2048 got=%08h/%0b exp=80012283/1", inst, err); end
   endtask

   task automatic test_jal_lui();
      logic [31:0] inst; logic err; int lat;
      single(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h00000800, inst, err, lat);
      checks++; if (inst !== 32'h001000EF || err !== 1'b0) begin errors++; $display("FAIL j_800 got=%08h/%0b exp=001000EF/0", inst, err); end
      single(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h00100000, inst, err, lat);
      checks++; if (inst !== 32'h800000EF || err !== 1'b1) begin errors++; $display("FAIL j_range got=%08h/%0b exp=800000EF/1", inst, err); end
      single(3'd3, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 32'h12345000, inst, err, lat);
      checks++; if (inst !== 32'h123451B7 || err !== 1'b0) begin errors++; $display("FAIL u_lui got=%08h/%0b exp=123451B7/0", inst, err); end
      single(3'd3, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 32'h12345001, inst, err, lat);
      checks++; if (inst !== 32'h123451B7 || err !== 1'b1) begin errors++; $display("FAIL u_low got=%08h/%0b exp=123451B7/1", inst, err); end
      single(3'd6, 7'b0110111, 5'd3, 5'd1, 5'd2, 3'b111, 32'h0, inst, err, lat);
      checks++; if (inst !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL fmt_illegal got=%08h/%0b exp=00000000/1", inst, err); end
      checks++; if (enc_count !== 16'd11 || err_count !== 8'd5) begin
         errors++; $display("FAIL mid_counters got=%0d/%0d exp=11/5", enc_count, err_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  pat;
      logic [11:0] idx;
      logic [31:0] exp;
      int sent, recv, cyc;
      pat = 4'b1001;
      sent = 0; recv = 0; cyc = 0;
      while (recv < 8 && cyc < 200) begin
         @(negedge clk);
         out_ready = pat[3 - (cyc % 4)];
         in_valid  = (sent < 8);
         in_fmt = 3'd0; in_opcode = 7'h13; in_rs1 = 5'd1; in_rs2 = 5'd0;
         in_funct3 = 3'd0; in_rd = 5'(sent); in_imm = 32'(sent);
         #1;
         if (!in_ready) begin
            checks++;
            if (!(out_valid && !out_ready)) begin
               errors++; $display("FAIL b2b_in_ready cyc=%0d in_ready=0 out_valid=%0b out_ready=%0b", cyc, out_valid, out_ready);
            end
         end
         if (out_valid && out_ready) begin
            idx = 12'(recv);
            exp = {idx, 5'd1, 3'd0, idx[4:0], 7'h13};
            $display("txn b2b word=%0d inst=%08h", recv, out_inst);
            checks++;
            if (out_inst !== exp) begin errors++; $display("FAIL b2b_word%0d got=%08h exp=%08h", recv, out_inst, exp); end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      checks++; if (recv !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", recv); end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained out_valid=%0b exp=0", out_valid); end
      checks++; if (enc_count !== 16'd19 || err_count !== 8'd5) begin
         errors++; $display("FAIL b2b_counters got=%0d/%0d exp=19/5", enc_count, err_count);
      end
   endtask

   task automatic test_reset_inflight();
      logic [31:0] inst; logic err; int lat;
      out_ready = 1'b0;
      send(3'd0, 7'b0000011, 5'd1, 5'd1, 5'd0, 3'b000, 32'd1);
      send(3'd0, 7'b0000011, 5'd2, 5'd1, 5'd0, 3'b000, 32'd2);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL full_stall in_ready=%0b out_valid=%0b exp=0/1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0 || enc_count !== 16'd0 || err_count !== 8'd0) begin
         errors++; $display("FAIL rst_flush got=%0b/%0d/%0d exp=0/0/0", out_valid, enc_count, err_count);
      end
      out_ready = 1'b1;
      single(3'd0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'hFFFFFFFC, inst, err, lat);
      checks++; if (inst !== 32'hFFC12283 || err !== 1'b0 || lat !== 2) begin
         errors++; $display("FAIL post_reset got=%08h/%0b lat=%0d exp=FFC12283/0 lat=2", inst, err, lat);
      end
      checks++; if (enc_count !== 16'd1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", enc_count); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
      test_reset();
      test_i_s();
      test_branch();
      test_i_bounds();
      test_jal_lui();
      test_back_to_back();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
